// File: rtl/sw_debounce.sv
// Two-flop synchroniser plus independent per-bit stability-counter debounce for raw slide switches.
// Optional macro SW_GLITCH_CNT_EN adds a saturating 16-bit count of aborted bounce windows.
module sw_debounce #(
    parameter int WIDTH     = 4,
    parameter int DB_CYCLES = 10,
    parameter int CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] sw_raw,
    output logic [WIDTH-1:0] sw_db,
    output logic [WIDTH-1:0] sw_rise,
    output logic [WIDTH-1:0] sw_fall,
    output logic             sw_changed,
    output logic             sw_all_zero
`ifdef SW_GLITCH_CNT_EN
    ,
    output logic [15:0]      glitch_cnt
`endif
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

    logic [WIDTH-1:0] s1_q, s1_d;
    logic [WIDTH-1:0] s2_q, s2_d;
    logic [WIDTH-1:0] db_q, db_d;
    logic [WIDTH-1:0] rise_q, rise_d;
    logic [WIDTH-1:0] fall_q, fall_d;
    logic             changed_q, changed_d;
    logic [CNT_W-1:0] cnt_q [WIDTH];
    logic [CNT_W-1:0] cnt_d [WIDTH];

`ifdef SW_GLITCH_CNT_EN
    logic             abort_s;
    logic [15:0]      glitch_q, glitch_d;
`endif

    // Next-state logic: synchroniser shift and per-bit stability counting.
    always_comb begin
        s1_d   = sw_raw;
        s2_d   = s1_q;
        db_d   = db_q;
        rise_d = {WIDTH{1'b0}};
        fall_d = {WIDTH{1'b0}};
`ifdef SW_GLITCH_CNT_EN
        abort_s = 1'b0;
`endif
        for (int i = 0; i < WIDTH; i++) begin
            cnt_d[i] = cnt_q[i];
            if (s2_q[i] == db_q[i]) begin
                cnt_d[i] = CNT_ZERO;
`ifdef SW_GLITCH_CNT_EN
                if (cnt_q[i] != CNT_ZERO) begin
                    abort_s = 1'b1;
                end else begin
                    abort_s = abort_s;
                end
`endif
            end else if (cnt_q[i] == CNT_LAST) begin
                // Threshold reached: commit the new level and pulse the matching edge.
                db_d[i]   = s2_q[i];
                cnt_d[i]  = CNT_ZERO;
                rise_d[i] = s2_q[i];
                fall_d[i] = ~s2_q[i];
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_ONE;
            end
        end
        changed_d = |(rise_d | fall_d);
    end

`ifdef SW_GLITCH_CNT_EN
    // Saturating aborted-bounce counter.
    always_comb begin
        if (abort_s && (glitch_q != 16'hFFFF)) begin
            glitch_d = glitch_q + 16'd1;
        end else begin
            glitch_d = glitch_q;
        end
    end

    // Glitch counter register, cleared only by reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            glitch_q <= 16'd0;
        end else begin
            glitch_q <= glitch_d;
        end
    end

    assign glitch_cnt = glitch_q;
`endif

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_q      <= {WIDTH{1'b0}};
            s2_q      <= {WIDTH{1'b0}};
            db_q      <= {WIDTH{1'b0}};
            rise_q    <= {WIDTH{1'b0}};
            fall_q    <= {WIDTH{1'b0}};
            changed_q <= 1'b0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= CNT_ZERO;
            end
        end else begin
            s1_q      <= s1_d;
            s2_q      <= s2_d;
            db_q      <= db_d;
            rise_q    <= rise_d;
            fall_q    <= fall_d;
            changed_q <= changed_d;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign sw_db       = db_q;
    assign sw_rise     = rise_q;
    assign sw_fall     = fall_q;
    assign sw_changed  = changed_q;
    assign sw_all_zero = (db_q == {WIDTH{1'b0}});

endmodule
